// File: rtl/id_ex_stage_register_pkg.sv
// Shared pipeline types for the segmented RISC-V core: ALU opcode classes and
// per-stage control bundles, each with a NOP/bubble constant.
package id_ex_stage_register_pkg;

  localparam logic [1:0] AluOpLdSt   = 2'b00;
  localparam logic [1:0] AluOpBranch = 2'b01;
  localparam logic [1:0] AluOpRType  = 2'b10;
  localparam logic [1:0] AluOpIType  = 2'b11;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
  } ex_ctrl_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic branch;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  localparam ex_ctrl_t  ExCtrlNop  = '{alu_op: AluOpLdSt, alu_src: 1'b0};
  localparam mem_ctrl_t MemCtrlNop = '{mem_read: 1'b0, mem_write: 1'b0, branch: 1'b0};
  localparam wb_ctrl_t  WbCtrlNop  = '{reg_write: 1'b0, mem_to_reg: 1'b0};

endpackage

// File: rtl/id_ex_stage_register_hazard_detection_unit.sv
// Load-use hazard detector: the load in EX writes a register that the
// instruction in decode reads, so decode must wait one cycle.
module id_ex_stage_register_hazard_detection_unit #(
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      ex_valid_in,
  input  logic                      ex_mem_read_in,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_in,
  input  logic                      id_valid_in,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_in,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_in,
  input  logic                      id_uses_rs1_in,
  input  logic                      id_uses_rs2_in,
  output logic                      hazard_out
);

  logic w_rs1_match;
  logic w_rs2_match;
  logic w_ex_load;

  assign w_rs1_match = id_uses_rs1_in && (id_rs1_in == ex_rd_in);
  assign w_rs2_match = id_uses_rs2_in && (id_rs2_in == ex_rd_in);
  // x0 is never written, so a load targeting it cannot create a dependency
  assign w_ex_load   = ex_valid_in && ex_mem_read_in && (ex_rd_in != '0);
  assign hazard_out  = w_ex_load && id_valid_in && (w_rs1_match || w_rs2_match);

endmodule

// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with load-use bubble insertion, stall/flush
// handling and a saturating count of inserted bubbles.
module id_ex_stage_register
  import id_ex_stage_register_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  input  logic [DATA_WIDTH-1:0]     pc_in,
  input  logic [DATA_WIDTH-1:0]     read_data_1_in,
  input  logic [DATA_WIDTH-1:0]     read_data_2_in,
  input  logic [DATA_WIDTH-1:0]     immediate_gen_in,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_in,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_in,
  input  logic [REG_ADDR_WIDTH-1:0] rd_in,
  input  logic                      uses_rs1_in,
  input  logic                      uses_rs2_in,
  input  logic [2:0]                funct3_in,
  input  logic                      funct7_b30_in,
  input  logic [1:0]                alu_op_in,
  input  logic                      alu_src_in,
  input  logic                      mem_read_in,
  input  logic                      mem_write_in,
  input  logic                      branch_in,
  input  logic                      reg_write_in,
  input  logic                      mem_to_reg_in,
  input  logic                      stall_in,
  input  logic                      flush_in,
  output logic                      valid_out,
  output logic [DATA_WIDTH-1:0]     pc_out,
  output logic [DATA_WIDTH-1:0]     read_data_1_out,
  output logic [DATA_WIDTH-1:0]     read_data_2_out,
  output logic [DATA_WIDTH-1:0]     immediate_gen_out,
  output logic [REG_ADDR_WIDTH-1:0] rs1_out,
  output logic [REG_ADDR_WIDTH-1:0] rs2_out,
  output logic [REG_ADDR_WIDTH-1:0] rd_out,
  output logic                      uses_rs1_out,
  output logic                      uses_rs2_out,
  output logic [2:0]                funct3_out,
  output logic                      funct7_b30_out,
  output logic [1:0]                alu_op_out,
  output logic                      alu_src_out,
  output logic                      mem_read_out,
  output logic                      mem_write_out,
  output logic                      branch_out,
  output logic                      reg_write_out,
  output logic                      mem_to_reg_out,
  output logic                      hazard_stall_out,
  output logic [CNT_WIDTH-1:0]      bubble_count_out
);

  logic                      r_valid;
  logic [DATA_WIDTH-1:0]     r_pc, r_rd1, r_rd2, r_imm;
  logic [REG_ADDR_WIDTH-1:0] r_rs1, r_rs2, r_rd;
  logic                      r_uses_rs1, r_uses_rs2;
  logic [2:0]                r_funct3;
  logic                      r_funct7_b30;
  ex_ctrl_t                  r_ex;
  mem_ctrl_t                 r_mem;
  wb_ctrl_t                  r_wb;
  logic [CNT_WIDTH-1:0]      r_cnt;

  logic                      w_hazard;
  ex_ctrl_t                  w_ex_in;
  mem_ctrl_t                 w_mem_in;
  wb_ctrl_t                  w_wb_in;
  logic [CNT_WIDTH-1:0]      w_cnt_inc;

  id_ex_stage_register_hazard_detection_unit #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_hdu (
    .ex_valid_in    (r_valid),
    .ex_mem_read_in (r_mem.mem_read),
    .ex_rd_in       (r_rd),
    .id_valid_in    (valid_in),
    .id_rs1_in      (rs1_in),
    .id_rs2_in      (rs2_in),
    .id_uses_rs1_in (uses_rs1_in),
    .id_uses_rs2_in (uses_rs2_in),
    .hazard_out     (w_hazard)
  );

  // An empty decode slot must not carry side-effecting control into EX
  assign w_ex_in   = valid_in ? '{alu_op: alu_op_in, alu_src: alu_src_in} : ExCtrlNop;
  assign w_mem_in  = valid_in ? '{mem_read: mem_read_in, mem_write: mem_write_in,
                                  branch: branch_in} : MemCtrlNop;
  assign w_wb_in   = valid_in ? '{reg_write: reg_write_in, mem_to_reg: mem_to_reg_in}
                              : WbCtrlNop;
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst || flush_in || (!stall_in && w_hazard)) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_imm        <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_uses_rs1   <= 1'b0;
      r_uses_rs2   <= 1'b0;
      r_funct3     <= '0;
      r_funct7_b30 <= 1'b0;
      r_ex         <= ExCtrlNop;
      r_mem        <= MemCtrlNop;
      r_wb         <= WbCtrlNop;
      r_cnt        <= rst ? '0 : w_cnt_inc;
    end else if (!stall_in) begin
      r_valid      <= valid_in;
      r_pc         <= pc_in;
      r_rd1        <= read_data_1_in;
      r_rd2        <= read_data_2_in;
      r_imm        <= immediate_gen_in;
      r_rs1        <= rs1_in;
      r_rs2        <= rs2_in;
      r_rd         <= rd_in;
      r_uses_rs1   <= uses_rs1_in;
      r_uses_rs2   <= uses_rs2_in;
      r_funct3     <= funct3_in;
      r_funct7_b30 <= funct7_b30_in;
      r_ex         <= w_ex_in;
      r_mem        <= w_mem_in;
      r_wb         <= w_wb_in;
    end
  end

  assign valid_out         = r_valid;
  assign pc_out            = r_pc;
  assign read_data_1_out   = r_rd1;
  assign read_data_2_out   = r_rd2;
  assign immediate_gen_out = r_imm;
  assign rs1_out           = r_rs1;
  assign rs2_out           = r_rs2;
  assign rd_out            = r_rd;
  assign uses_rs1_out      = r_uses_rs1;
  assign uses_rs2_out      = r_uses_rs2;
  assign funct3_out        = r_funct3;
  assign funct7_b30_out    = r_funct7_b30;
  assign alu_op_out        = r_ex.alu_op;
  assign alu_src_out       = r_ex.alu_src;
  assign mem_read_out      = r_mem.mem_read;
  assign mem_write_out     = r_mem.mem_write;
  assign branch_out        = r_mem.branch;
  assign reg_write_out     = r_wb.reg_write;
  assign mem_to_reg_out    = r_wb.mem_to_reg;
  assign hazard_stall_out  = w_hazard;
  assign bubble_count_out  = r_cnt;

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Directed bench for id_ex_stage_register: per-cycle vector table plus hand
// sequences for counter saturation and reset during a hazard stall.
module tb_id_ex_stage_register;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in, uses_rs1_in, uses_rs2_in, funct7_b30_in, alu_src_in;
  logic [DW-1:0] pc_in, read_data_1_in, read_data_2_in, immediate_gen_in;
  logic [AW-1:0] rs1_in, rs2_in, rd_in;
  logic [2:0]    funct3_in;
  logic [1:0]    alu_op_in;
  logic          mem_read_in, mem_write_in, branch_in, reg_write_in, mem_to_reg_in;
  logic          stall_in, flush_in;
  logic          valid_out, uses_rs1_out, uses_rs2_out, funct7_b30_out, alu_src_out;
  logic [DW-1:0] pc_out, read_data_1_out, read_data_2_out, immediate_gen_out;
  logic [AW-1:0] rs1_out, rs2_out, rd_out;
  logic [2:0]    funct3_out;
  logic [1:0]    alu_op_out;
  logic          mem_read_out, mem_write_out, branch_out, reg_write_out, mem_to_reg_out;
  logic          hazard_stall_out;
  logic [CW-1:0] bubble_count_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage_register #(
    .DATA_WIDTH     (DW),
    .REG_ADDR_WIDTH (AW),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .valid_in          (valid_in),
    .pc_in             (pc_in),
    .read_data_1_in    (read_data_1_in),
    .read_data_2_in    (read_data_2_in),
    .immediate_gen_in  (immediate_gen_in),
    .rs1_in            (rs1_in),
    .rs2_in            (rs2_in),
    .rd_in             (rd_in),
    .uses_rs1_in       (uses_rs1_in),
    .uses_rs2_in       (uses_rs2_in),
    .funct3_in         (funct3_in),
    .funct7_b30_in     (funct7_b30_in),
    .alu_op_in         (alu_op_in),
    .alu_src_in        (alu_src_in),
    .mem_read_in       (mem_read_in),
    .mem_write_in      (mem_write_in),
    .branch_in         (branch_in),
    .reg_write_in      (reg_write_in),
    .mem_to_reg_in     (mem_to_reg_in),
    .stall_in          (stall_in),
    .flush_in          (flush_in),
    .valid_out         (valid_out),
    .pc_out            (pc_out),
    .read_data_1_out   (read_data_1_out),
    .read_data_2_out   (read_data_2_out),
    .immediate_gen_out (immediate_gen_out),
    .rs1_out           (rs1_out),
    .rs2_out           (rs2_out),
    .rd_out            (rd_out),
    .uses_rs1_out      (uses_rs1_out),
    .uses_rs2_out      (uses_rs2_out),
    .funct3_out        (funct3_out),
    .funct7_b30_out    (funct7_b30_out),
    .alu_op_out        (alu_op_out),
    .alu_src_out       (alu_src_out),
    .mem_read_out      (mem_read_out),
    .mem_write_out     (mem_write_out),
    .branch_out        (branch_out),
    .reg_write_out     (reg_write_out),
    .mem_to_reg_out    (mem_to_reg_out),
    .hazard_stall_out  (hazard_stall_out),
    .bubble_count_out  (bubble_count_out)
  );

  typedef struct {
    logic          v, u1, u2, mr, rw, fl, st;
    logic [AW-1:0] rs1, rs2, rd;
    logic [DW-1:0] d1, d2;
    logic          e_haz, e_v, e_rw, e_mr;
    logic [AW-1:0] e_rd, e_rs1, e_rs2;
    logic [DW-1:0] e_d1, e_d2;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Side fields are derived from d1/d2 so their expectations follow e_d1/e_d2
  task automatic drive(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [AW-1:0] rd, input logic u1, input logic u2,
                       input logic mr, input logic rw, input logic [DW-1:0] d1,
                       input logic [DW-1:0] d2, input logic fl, input logic st);
    valid_in = v; rs1_in = rs1; rs2_in = rs2; rd_in = rd;
    uses_rs1_in = u1; uses_rs2_in = u2; mem_read_in = mr; reg_write_in = rw;
    mem_to_reg_in = mr; read_data_1_in = d1; read_data_2_in = d2;
    pc_in = {d1[15:0], d2[15:0]}; immediate_gen_in = {d2[15:0], d1[15:0]};
    funct3_in = d1[2:0]; funct7_b30_in = d2[0]; alu_op_in = d1[5:4];
    alu_src_in = d2[1]; mem_write_in = d1[8]; branch_in = d1[9];
    flush_in = fl; stall_in = st;
  endtask

  function automatic vec_t mk(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
      input logic [AW-1:0] rd, input logic u1, input logic u2, input logic mr, input logic rw,
      input logic [DW-1:0] d1, input logic [DW-1:0] d2, input logic fl, input logic st,
      input logic e_haz, input logic e_v, input logic [AW-1:0] e_rd, input logic [AW-1:0] e_rs1,
      input logic [AW-1:0] e_rs2, input logic [DW-1:0] e_d1, input logic [DW-1:0] e_d2,
      input logic e_rw, input logic e_mr, input logic [CW-1:0] e_cnt);
    vec_t r;
    r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.u1 = u1; r.u2 = u2; r.mr = mr; r.rw = rw;
    r.d1 = d1; r.d2 = d2; r.fl = fl; r.st = st; r.e_haz = e_haz; r.e_v = e_v; r.e_rd = e_rd;
    r.e_rs1 = e_rs1; r.e_rs2 = e_rs2; r.e_d1 = e_d1; r.e_d2 = e_d2; r.e_rw = e_rw;
    r.e_mr = e_mr; r.e_cnt = e_cnt;
    return r;
  endfunction

  initial begin
    // Reset with every input high
    rst = 1'b1;
    drive(1, '1, '1, '1, 1, 1, 1, 1, '1, '1, 1, 1);
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 64'({valid_out, pc_out, read_data_1_out, read_data_2_out,
          immediate_gen_out, rs1_out, rs2_out, rd_out, uses_rs1_out, uses_rs2_out,
          funct3_out, funct7_b30_out, alu_op_out, alu_src_out, mem_read_out, mem_write_out,
          branch_out, reg_write_out, mem_to_reg_out} != '0), 64'd0);
    check("reset_count", 64'(bubble_count_out), 64'd0);
    check("reset_hazard", 64'(hazard_stall_out), 64'd0);
    rst = 1'b0;

    //        v rs1 rs2 rd u1 u2 mr rw d1      d2      fl st haz ev erd ers1 ers2 ed1    ed2    erw emr cnt
    vecs.push_back(mk(1, 1, 2, 3, 1, 1, 0, 1, 'h5,   'h7,   0, 0, 0, 1, 3, 1, 2, 'h5,   'h7,   1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 5, 1, 0, 1, 1, 'h100, 'h0,   0, 0, 0, 1, 5, 1, 0, 'h100, 'h0,   1, 1, 0));
    vecs.push_back(mk(1, 5, 1, 6, 1, 1, 0, 1, 'hAA,  'hBB,  0, 0, 1, 0, 0, 0, 0, 'h0,   'h0,   0, 0, 1));
    vecs.push_back(mk(1, 5, 1, 6, 1, 1, 0, 1, 'hAA,  'hBB,  0, 0, 0, 1, 6, 5, 1, 'hAA,  'hBB,  1, 0, 1));
    vecs.push_back(mk(1, 2, 0, 0, 1, 0, 1, 1, 'h200, 'h0,   0, 0, 0, 1, 0, 2, 0, 'h200, 'h0,   1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 7, 1, 1, 0, 1, 'h0,   'h0,   0, 0, 0, 1, 7, 0, 0, 'h0,   'h0,   1, 0, 1));
    vecs.push_back(mk(1, 1, 0, 8, 1, 0, 1, 1, 'h300, 'h0,   0, 0, 0, 1, 8, 1, 0, 'h300, 'h0,   1, 1, 1));
    vecs.push_back(mk(1, 2, 8, 0, 1, 0, 0, 0, 'h10,  'h20,  0, 0, 0, 1, 0, 2, 8, 'h10,  'h20,  0, 0, 1));
    vecs.push_back(mk(1, 3, 0, 9, 1, 0, 1, 1, 'h400, 'h0,   0, 0, 0, 1, 9, 3, 0, 'h400, 'h0,   1, 1, 1));
    vecs.push_back(mk(1, 1, 9, 10, 1, 1, 0, 1, 'h11, 'h22,  0, 0, 1, 0, 0, 0, 0, 'h0,   'h0,   0, 0, 2));
    vecs.push_back(mk(1, 1, 9, 10, 1, 1, 0, 1, 'h11, 'h22,  0, 0, 0, 1, 10, 1, 9, 'h11, 'h22,  1, 0, 2));
    vecs.push_back(mk(1, 1, 2, 11, 1, 1, 0, 1, 'h33, 'h44,  1, 1, 0, 0, 0, 0, 0, 'h0,   'h0,   0, 0, 3));
    vecs.push_back(mk(0, 4, 6, 12, 1, 1, 0, 1, 'h55, 'h0,   0, 0, 0, 0, 12, 4, 6, 'h55, 'h0,   0, 0, 3));
    vecs.push_back(mk(1, 1, 2, 13, 1, 1, 0, 1, 'h66, 'h77,  0, 0, 0, 1, 13, 1, 2, 'h66, 'h77,  1, 0, 3));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1, 3, 4, 14, 1, 1, 0, 1, 'h99, 'h98, 0, 1, 0, 1, 13, 1, 2, 'h66, 'h77, 1, 0, 3));
    vecs.push_back(mk(1, 1, 0, 15, 1, 0, 1, 1, 'h500, 'h0,  0, 0, 0, 1, 15, 1, 0, 'h500, 'h0,  1, 1, 3));
    vecs.push_back(mk(1, 15, 2, 16, 1, 1, 0, 1, 'h600, 'h700, 0, 1, 1, 1, 15, 1, 0, 'h500, 'h0, 1, 1, 3));
    vecs.push_back(mk(1, 15, 2, 16, 1, 1, 0, 1, 'h600, 'h700, 0, 0, 1, 0, 0, 0, 0, 'h0, 'h0,   0, 0, 4));
    vecs.push_back(mk(1, 15, 2, 16, 1, 1, 0, 1, 'h600, 'h700, 0, 0, 0, 1, 16, 15, 2, 'h600, 'h700, 1, 0, 4));

    foreach (vecs[i]) begin
      vec_t t;
      logic [DW-1:0] d1e, d2e;
      t = vecs[i];
      d1e = t.e_d1;
      d2e = t.e_d2;
      drive(t.v, t.rs1, t.rs2, t.rd, t.u1, t.u2, t.mr, t.rw, t.d1, t.d2, t.fl, t.st);
      #2;
      check($sformatf("v%0d_hazard", i), 64'(hazard_stall_out), 64'(t.e_haz));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid", i), 64'(valid_out), 64'(t.e_v));
      check($sformatf("v%0d_regs", i), 64'({rd_out, rs1_out, rs2_out}),
            64'({t.e_rd, t.e_rs1, t.e_rs2}));
      check($sformatf("v%0d_rd1", i), 64'(read_data_1_out), 64'(d1e));
      check($sformatf("v%0d_rd2", i), 64'(read_data_2_out), 64'(d2e));
      check($sformatf("v%0d_pc_imm", i), {pc_out, immediate_gen_out},
            {d1e[15:0], d2e[15:0], d2e[15:0], d1e[15:0]});
      check($sformatf("v%0d_funct", i), 64'({funct3_out, funct7_b30_out}),
            64'({d1e[2:0], d2e[0]}));
      check($sformatf("v%0d_wb_mem", i),
            64'({reg_write_out, mem_read_out, mem_to_reg_out}),
            64'({t.e_rw, t.e_mr, t.e_mr}));
      check($sformatf("v%0d_ex_ctrl", i),
            64'({alu_op_out, alu_src_out, mem_write_out, branch_out}),
            64'(t.e_v ? {d1e[5:4], d2e[1], d1e[8], d1e[9]} : 5'b0));
      check($sformatf("v%0d_count", i), 64'(bubble_count_out), 64'(t.e_cnt));
    end

    // Saturation: 20 load-use bubbles on top of the 4 already counted
    for (int k = 0; k < 20; k++) begin
      drive(1, 1, 0, 5, 1, 0, 1, 1, 'h700, 'h0, 0, 0);
      #2;
      check($sformatf("sat%0d_lw_hazard", k), 64'(hazard_stall_out), 64'd0);
      @(posedge clk);
      #1;
      drive(1, 5, 1, 6, 1, 1, 0, 1, 'h800, 'h0, 0, 0);
      #2;
      check($sformatf("sat%0d_add_hazard", k), 64'(hazard_stall_out), 64'd1);
      @(posedge clk);
      #1;
      check($sformatf("sat%0d_count", k), 64'(bubble_count_out),
            64'((k + 5 > 15) ? 15 : k + 5));
    end

    // Reset while a hazard is being held by stall_in
    drive(1, 1, 0, 5, 1, 0, 1, 1, 'h900, 'h0, 0, 0);
    @(posedge clk);
    #1;
    drive(1, 5, 1, 6, 1, 1, 0, 1, 'hA00, 'h0, 0, 1);
    #2;
    check("rst_stall_hazard_before", 64'(hazard_stall_out), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_stall_hazard_after", 64'(hazard_stall_out), 64'd0);
    check("rst_stall_valid", 64'(valid_out), 64'd0);
    check("rst_stall_count", 64'(bubble_count_out), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_register.md
Name: id_ex_stage_register

Overview:
- ID/EX pipeline register of the segmented RISC-V core. It sits between decode/register-file read and the ALU encapsulator stage.
- Latches operands, immediate, register indices, funct fields and EX/MEM/WB control.
- Contains the load-use hazard detector. It inserts exactly one bubble and requests an IF/ID stall.
- Honours external stall and flush, and counts inserted bubbles.

Parameters:
DATA_WIDTH, 32, operand/immediate/PC width
REG_ADDR_WIDTH, 5, register index width
CNT_WIDTH, 16, bubble counter width

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
valid_in  in  1  decode slot holds a real instruction
pc_in  in  DATA_WIDTH  instruction PC
read_data_1_in / read_data_2_in  in  DATA_WIDTH  register-file operands
immediate_gen_in  in  DATA_WIDTH  sign-extended immediate
rs1_in / rs2_in / rd_in  in  REG_ADDR_WIDTH  register indices
uses_rs1_in / uses_rs2_in  in  1  instruction reads rs1/rs2
funct3_in  in  3  funct3
funct7_b30_in  in  1  instruction bit 30
alu_op_in  in  2  ALU controller opcode class
alu_src_in  in  1  0 = reg operand 2, 1 = immediate
mem_read_in / mem_write_in / branch_in / reg_write_in / mem_to_reg_in  in  1 each  control
stall_in  in  1  global hold (memory wait)
flush_in  in  1  branch-taken flush of decode slot
(each _in above has a registered _out counterpart of identical width)
valid_out  out  1  EX slot holds a real instruction
hazard_stall_out  out  1  combinational; IF/ID and PC must hold
bubble_count_out  out  CNT_WIDTH  bubbles inserted since reset

Behaviour:
- Clocking and reset:
  - Single clock; all state updates on the rising edge of clk.
  - Synchronous active-high rst: every _out, valid_out and bubble_count_out is 0 next edge.
  - A zeroed slot is a NOP bubble: reg_write, mem_read, mem_write and branch are all 0.
- Hazard detect (combinational). hazard_stall_out = valid_out & mem_read_out & (rd_out != 0) & valid_in & ((uses_rs1_in & rs1_in == rd_out) | (uses_rs2_in & rs2_in == rd_out)).
- Per-edge priority (highest first):
  1. rst: clear everything.
  2. flush_in: load a bubble (valid_out = 0, all control 0; data fields don't-care, cleared to 0). Flush overrides stall_in and the hazard.
  3. stall_in: hold every output unchanged. hazard_stall_out is still driven, but no bubble is inserted while held.
  4. hazard_stall_out: load a bubble.
  5. Otherwise: capture all _in into _out. valid_out = valid_in, and control is gated by valid_in (valid_in = 0 means control 0).
- Latency: 1 cycle from _in to _out.
- Single-bubble guarantee. After a hazard bubble, valid_out = 0, so hazard_stall_out falls next cycle. The held decode instruction is then captured.
- Bubble counter:
  - Increments on each edge that loads a bubble due to the hazard or flush_in. Bubbles caused by valid_in = 0 are not counted.
  - Saturates at all-ones; no wrap.
- x0 destination never raises a hazard.
- Reset mid-stall: rst wins; hazard_stall_out is 0 the following cycle.

Decomposition:
- Shared package (core pipeline pkg):
  - alu_op class constants (2'b00 load/store add, 2'b01 branch, 2'b10 R-type, 2'b11 I-type).
  - struct ex_ctrl_t {alu_op, alu_src}, mem_ctrl_t {mem_read, mem_write, branch}, wb_ctrl_t {reg_write, mem_to_reg}.
  - NOP/bubble constant for each struct.
- Sub-module hazard_detection_unit: purely combinational, computes hazard_stall_out. The register and counter stay in the top module.

Test Plan:
1. Reset: drive all _in = 1s, rst = 1 for 2 cycles -> all _out = 0, valid_out = 0, bubble_count_out = 0.
2. Plain capture: add x3,x1,x2 with read_data_1_in = 32'h5, read_data_2_in = 32'h7, rd_in = 3 -> next cycle read_data_1_out = 5, read_data_2_out = 7, rd_out = 3, valid_out = 1, reg_write_out = 1.
3. Load-use: lw x5 in EX (mem_read_out = 1, rd_out = 5), decode add x6,x5,x1 (uses_rs1_in = 1) -> hazard_stall_out = 1 that cycle. Next cycle is a bubble (valid_out = 0, reg_write_out = 0) and bubble_count_out = 1. The following cycle the add is captured and hazard_stall_out = 0.
4. x0 / unused source: lw x0 in EX followed by add using x0 -> no hazard. Also sw whose rs2 = rd_out with uses_rs2_in = 0 -> no hazard.
5. Flush vs stall: flush_in = 1 and stall_in = 1 on the same edge with a valid add in decode -> bubble loaded, counter +1. Then stall_in alone for 3 cycles -> outputs constant.
6. Saturation: with CNT_WIDTH = 4, force 20 hazard bubbles -> bubble_count_out stops at 4'hF.
